// File: rtl/uio_bus_if.sv
// Bus bundle between the two requesters, the uio pads and the uio bus arbiter.
// The arbiter uses the slave modport; the requester/pad side uses master.
interface uio_bus_if;
  logic       ena;
  logic [1:0] req;
  logic [1:0] wr;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] uio_in;
  logic [1:0] gnt;
  logic [7:0] rdata;
  logic [1:0] rvalid;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       busy;

  modport master (
    output ena, req, wr, wdata0, wdata1, uio_in,
    input  gnt, rdata, rvalid, uio_out, uio_oe, busy
  );

  modport slave (
    input  ena, req, wr, wdata0, wdata1, uio_in,
    output gnt, rdata, rvalid, uio_out, uio_oe, busy
  );
endinterface

// File: rtl/uio_bus_arbiter.sv
// Round-robin time-sharing of the 8-bit uio pad bus between two requesters,
// with idle turnaround cycles so two owners never drive back to back.
module uio_bus_arbiter #(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input logic       clk,
  input logic       rst,
  uio_bus_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

  state_t      state;
  logic        owner;
  logic        own_wr;
  logic        last;
  logic [7:0]  hold;
  logic [3:0]  turn_cnt;

  logic        pick;
  logic        pick_wr;
  logic [7:0]  pick_data;
  logic [7:0]  owner_data;
  logic        req_own;
  logic        req_oth;
  logic        stay_own;
  logic        turn_done;
  logic        grant_now;

  always_comb begin
    pick = ~last;
    if (bus.req == 2'b01)      pick = 1'b0;
    else if (bus.req == 2'b10) pick = 1'b1;
    pick_wr    = bus.wr[pick];
    pick_data  = pick  ? bus.wdata1 : bus.wdata0;
    owner_data = owner ? bus.wdata1 : bus.wdata0;
    req_own    = bus.req[owner];
    req_oth    = bus.req[~owner];
    stay_own   = bus.ena && req_own && !(req_oth && (hold == 8'(MAX_HOLD - 1)));
    turn_done  = (turn_cnt == 4'(TURNAROUND - 1));
    grant_now  = bus.ena && (bus.req != 2'b00) &&
                 ((state == IDLE) || ((state == TURN) && turn_done));
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      own_wr      <= 1'b0;
      last        <= 1'b1;
      hold        <= '0;
      turn_cnt    <= '0;
      bus.gnt     <= '0;
      bus.uio_oe  <= '0;
      bus.uio_out <= '0;
      bus.rdata   <= '0;
      bus.rvalid  <= '0;
    end else begin
      bus.rvalid <= '0;
      case (state)
        IDLE: ;
        OWN: begin
          if (stay_own) begin
            if (req_oth && (hold != '1)) hold <= hold + 8'd1;
            if (own_wr) begin
              bus.uio_out <= owner_data;
            end else begin
              bus.rdata  <= bus.uio_in;
              bus.rvalid <= owner ? 2'b10 : 2'b01;
            end
          end else begin
            bus.gnt     <= '0;
            bus.uio_oe  <= '0;
            bus.uio_out <= '0;
            turn_cnt    <= '0;
            state       <= (bus.req == 2'b00) ? IDLE : TURN;
          end
        end
        TURN: begin
          if (!turn_done) turn_cnt <= turn_cnt + 4'd1;
          else            state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A grant from IDLE or at the end of TURN overrides the fall-back to IDLE above.
      if (grant_now) begin
        state       <= OWN;
        owner       <= pick;
        last        <= pick;
        own_wr      <= pick_wr;
        hold        <= '0;
        bus.gnt     <= pick ? 2'b10 : 2'b01;
        bus.uio_oe  <= pick_wr ? 8'hFF : 8'h00;
        bus.uio_out <= pick_wr ? pick_data : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: directed scenarios then random
// traffic, all compared against a cycle-level ownership model.
module tb_uio_bus_arbiter;

  localparam int TA = 2;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  uio_bus_if bus ();

  uio_bus_arbiter #(.TURNAROUND(TA), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus (-1 = nobody), idle gap still to run, round-robin memory.
  int         m_owner, m_gap, m_last, m_held;
  bit         m_wr;
  logic [7:0] e_out, e_rdata;
  logic [1:0] e_rvalid;
  logic [1:0] prev_wgnt;

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_last = 1; m_held = 0; m_wr = 1'b0;
    e_out = 8'h00; e_rdata = 8'h00; e_rvalid = 2'b00;
  endtask

  task automatic model_grant(input logic [7:0] wd0, input logic [7:0] wd1);
    int p;
    if (bus.req == 2'b01)      p = 0;
    else if (bus.req == 2'b10) p = 1;
    else                       p = 1 - m_last;
    m_owner = p;
    m_last  = p;
    m_wr    = bus.wr[p];
    m_held  = 0;
    e_out   = m_wr ? ((p == 1) ? wd1 : wd0) : 8'h00;
  endtask

  task automatic model_step();
    int oth;
    bit decide;
    e_rvalid = 2'b00;
    e_out    = 8'h00;
    if (m_owner >= 0) begin
      oth = 1 - m_owner;
      if (bus.ena && bus.req[m_owner] && !(m_held >= MH - 1 && bus.req[oth])) begin
        if (bus.req[oth]) m_held++;
        if (m_wr) e_out = (m_owner == 1) ? bus.wdata1 : bus.wdata0;
        else begin
          e_rdata  = bus.uio_in;
          e_rvalid = 2'(1 << m_owner);
        end
      end else begin
        m_owner = -1;
        m_gap   = (bus.req == 2'b00) ? 0 : TA;
      end
    end else begin
      decide = (m_gap <= 1);
      if (m_gap > 0) m_gap--;
      if (decide && bus.ena && bus.req != 2'b00) model_grant(bus.wdata0, bus.wdata1);
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    logic [1:0] e_gnt;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    e_gnt = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
    chk("gnt",     {6'd0, bus.gnt},    {6'd0, e_gnt});
    chk("uio_oe",  bus.uio_oe,         (m_owner >= 0 && m_wr) ? 8'hFF : 8'h00);
    chk("uio_out", bus.uio_out,        e_out);
    chk("rdata",   bus.rdata,          e_rdata);
    chk("rvalid",  {6'd0, bus.rvalid}, {6'd0, e_rvalid});
    chk("busy",    {7'd0, bus.busy},   {7'd0, (m_owner >= 0 || m_gap > 0)});
    if (bus.uio_oe == 8'hFF && prev_wgnt != 2'b00)
      chk("no_direct_handoff", {6'd0, bus.gnt}, {6'd0, prev_wgnt});
    prev_wgnt = (bus.uio_oe == 8'hFF) ? bus.gnt : 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    prev_wgnt  = 2'b00;
    bus.ena    = 1'b0;
    bus.req    = 2'b00;
    bus.wr     = 2'b00;
    bus.wdata0 = 8'h00;
    bus.wdata1 = 8'h00;
    bus.uio_in = 8'h00;
    do_reset();
    bus.ena = 1'b1;
    ticks(2);

    // Single write by requester 0, then async reset mid-grant.
    bus.req = 2'b01; bus.wr = 2'b01; bus.wdata0 = 8'hA5;
    ticks(3);
    rst = 1'b1;
    #1;
    chk("async_rst_oe",  bus.uio_oe, 8'h00);
    chk("async_rst_gnt", {6'd0, bus.gnt}, 8'h00);
    tick();
    rst = 1'b0; bus.req = 2'b00;
    tick();

    // Read capture by requester 1.
    bus.req = 2'b10; bus.wr = 2'b00; bus.uio_in = 8'h3C;
    ticks(3);
    bus.uio_in = 8'h5A;
    ticks(2);
    bus.req = 2'b00;
    ticks(3);

    // Tie from IDLE after reset, then release by requester 0.
    do_reset();
    bus.req = 2'b11; bus.wr = 2'b11; bus.wdata0 = 8'h11; bus.wdata1 = 8'h22;
    ticks(2);
    bus.req = 2'b10;
    ticks(TA + 3);

    // Preemption with both requests held.
    bus.req = 2'b11;
    ticks(4 * (MH + TA) + 2);
    bus.req = 2'b00;
    ticks(3);

    // Turnaround abandonment.
    do_reset();
    bus.req = 2'b01;
    ticks(2);
    bus.req = 2'b10;
    tick();
    bus.req = 2'b00;
    ticks(TA + 2);

    // ena gating.
    bus.req = 2'b11;
    ticks(3);
    bus.ena = 1'b0;
    ticks(TA + 4);
    bus.ena = 1'b1;
    ticks(6);
    bus.req = 2'b00;
    ticks(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 79) == 0);
      bus.ena    = ($urandom_range(0, 9) != 0);
      bus.req    = 2'($urandom_range(0, 3));
      bus.wr     = 2'($urandom_range(0, 3));
      bus.wdata0 = 8'($urandom);
      bus.wdata1 = 8'($urandom);
      bus.uio_in = 8'($urandom);
      tick();
    end
    rst = 1'b0;
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
